// File: rtl/frog_game_ctrl.sv
// Game-state controller for frogger: lives, level, score, respawn and freeze control.
// Define GAME_CTRL_CONTINUE_EN to keep the current level when restarting from OVER.
module frog_game_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int WIN_FRAMES   = 30,
    parameter int MAX_LEVEL    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       death_collision,
    input  logic       win_collision,
    output logic       frog_respawn,
    output logic       freeze,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic [6:0] score,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        DYING = 3'd2,
        WIN   = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [1:0] LIVES_RELOAD = 2'(LIVES_INIT);
    localparam logic [3:0] LEVEL_MAX    = 4'(MAX_LEVEL);
    localparam logic [6:0] SCORE_MAX    = 7'd99;
    // Exit happens on the tick that would complete the count, so compare against N-1.
    localparam logic [5:0] DEATH_LAST   = 6'(DEATH_FRAMES - 1);
    localparam logic [5:0] WIN_LAST     = 6'(WIN_FRAMES - 1);

    state_t     cur_state, nxt_state;
    logic [5:0] timer, timer_nxt;
    logic [1:0] lives_nxt;
    logic [3:0] level_nxt;
    logic [6:0] score_nxt;
    logic       freeze_nxt;
    logic       respawn_nxt;
    logic       game_over_nxt;

    assign state = cur_state;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        nxt_state     = cur_state;
        timer_nxt     = timer;
        lives_nxt     = lives;
        level_nxt     = level;
        score_nxt     = score;
        freeze_nxt    = freeze;
        respawn_nxt   = 1'b0;

        unique case (cur_state)
            IDLE: begin
                if (start) begin
                    nxt_state   = PLAY;
                    respawn_nxt = 1'b1;
                    freeze_nxt  = 1'b0;
                end
            end
            PLAY: begin
                if (death_collision) begin
                    nxt_state  = DYING;
                    lives_nxt  = lives - 2'd1;
                    freeze_nxt = 1'b1;
                end else if (win_collision) begin
                    nxt_state  = WIN;
                    freeze_nxt = 1'b1;
                    if (level != LEVEL_MAX) level_nxt = level + 4'd1;
                    if (score != SCORE_MAX) score_nxt = score + 7'd1;
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (timer == DEATH_LAST) begin
                        if (lives == 2'd0) begin
                            nxt_state = OVER;
                        end else begin
                            nxt_state   = PLAY;
                            respawn_nxt = 1'b1;
                            freeze_nxt  = 1'b0;
                        end
                    end else begin
                        timer_nxt = timer + 6'd1;
                    end
                end
            end
            WIN: begin
                if (frame_tick) begin
                    if (timer == WIN_LAST) begin
                        nxt_state   = PLAY;
                        respawn_nxt = 1'b1;
                        freeze_nxt  = 1'b0;
                    end else begin
                        timer_nxt = timer + 6'd1;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    nxt_state   = PLAY;
                    respawn_nxt = 1'b1;
                    freeze_nxt  = 1'b0;
                    lives_nxt   = LIVES_RELOAD;
                    score_nxt   = 7'd0;
`ifdef GAME_CTRL_CONTINUE_EN
                    level_nxt   = level;
`else
                    level_nxt   = 4'd1;
`endif
                end
            end
            default: begin
                nxt_state  = IDLE;
                freeze_nxt = 1'b1;
            end
        endcase

        // Timer restarts on every state entry so a stale count never shortens the next phase.
        if (nxt_state != cur_state) timer_nxt = 6'd0;

        game_over_nxt = (nxt_state == OVER);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= IDLE;
            timer        <= 6'd0;
            lives        <= LIVES_RELOAD;
            level        <= 4'd1;
            score        <= 7'd0;
            freeze       <= 1'b1;
            frog_respawn <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            timer        <= timer_nxt;
            lives        <= lives_nxt;
            level        <= level_nxt;
            score        <= score_nxt;
            freeze       <= freeze_nxt;
            frog_respawn <= respawn_nxt;
            game_over    <= game_over_nxt;
        end
    end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Self-checking bench for frog_game_ctrl: directed scenarios plus random stimulus against a game-rule model.
// Honours GAME_CTRL_CONTINUE_EN the same way the design does.
module tb_frog_game_ctrl;

    localparam int LIVES_INIT   = 3;
    localparam int DEATH_FRAMES = 60;
    localparam int WIN_FRAMES   = 30;
    localparam int MAX_LEVEL    = 9;

    localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_WIN = 3, S_OVER = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       death_collision = 1'b0;
    logic       win_collision = 1'b0;
    logic       frog_respawn;
    logic       freeze;
    logic [1:0] lives;
    logic [3:0] level;
    logic [6:0] score;
    logic       game_over;
    logic [2:0] state;

    frog_game_ctrl #(
        .LIVES_INIT  (LIVES_INIT),
        .DEATH_FRAMES(DEATH_FRAMES),
        .WIN_FRAMES  (WIN_FRAMES),
        .MAX_LEVEL   (MAX_LEVEL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_tick     (frame_tick),
        .start          (start),
        .death_collision(death_collision),
        .win_collision  (win_collision),
        .frog_respawn   (frog_respawn),
        .freeze         (freeze),
        .lives          (lives),
        .level          (level),
        .score          (score),
        .game_over      (game_over),
        .state          (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tick_period = 10;
    int resp_cnt = 0;

    // Game-rule model: plain integers, counting ticks up to the phase length.
    int m_state, m_lives, m_level, m_score, m_ticks;
    bit m_freeze, m_resp;

    task automatic model_reset();
        m_state = S_IDLE; m_lives = LIVES_INIT; m_level = 1; m_score = 0;
        m_ticks = 0; m_freeze = 1; m_resp = 0;
    endtask

    task automatic enter_play();
        m_state = S_PLAY; m_resp = 1; m_freeze = 0;
    endtask

    task automatic model_step(bit t, bit s, bit d, bit w);
        m_resp = 0;
        case (m_state)
            S_IDLE: if (s) enter_play();
            S_PLAY: begin
                if (d) begin
                    m_state = S_DYING; m_lives = m_lives - 1; m_freeze = 1; m_ticks = 0;
                end else if (w) begin
                    m_state = S_WIN; m_freeze = 1; m_ticks = 0;
                    m_level = (m_level + 1 > MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
                    m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
                end
            end
            S_DYING: if (t) begin
                m_ticks++;
                if (m_ticks == DEATH_FRAMES) begin
                    if (m_lives == 0) m_state = S_OVER;
                    else enter_play();
                end
            end
            S_WIN: if (t) begin
                m_ticks++;
                if (m_ticks == WIN_FRAMES) enter_play();
            end
            S_OVER: if (s) begin
                enter_play();
                m_lives = LIVES_INIT; m_score = 0;
`ifndef GAME_CTRL_CONTINUE_EN
                m_level = 1;
`endif
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all(string tag);
        cmp({tag, ".state"},     32'(state),        32'(m_state));
        cmp({tag, ".lives"},     32'(lives),        32'(m_lives));
        cmp({tag, ".level"},     32'(level),        32'(m_level));
        cmp({tag, ".score"},     32'(score),        32'(m_score));
        cmp({tag, ".freeze"},    32'(freeze),       32'(m_freeze));
        cmp({tag, ".respawn"},   32'(frog_respawn), 32'(m_resp));
        cmp({tag, ".game_over"}, 32'(game_over),    32'(m_state == S_OVER));
    endtask

    // One clock: model consumes the pre-edge inputs, outputs are checked 1 ns after the edge.
    task automatic cycle();
        bit t, s, d, w;
        t = frame_tick; s = start; d = death_collision; w = win_collision;
        @(posedge clk);
        model_step(t, s, d, w);
        #1;
        check_all("cyc");
        if (frog_respawn === 1'b1) resp_cnt++;
        cyc++;
        if (tick_period > 0) frame_tick = (cyc % tick_period == 0);
        else frame_tick = ($urandom_range(0, 2) == 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_state(int st, int budget, string tag);
        int n = 0;
        while (state !== 3'(st) && n < budget) begin
            cycle();
            n++;
        end
        cmp(tag, 32'(state), 32'(st));
    endtask

    // Reset asserted between clock edges; outputs must follow without an edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Start from IDLE.
        tick_period = 10;
        cycle();
        cmp("idle_hold", 32'(state), S_IDLE);
        pulse_start();
        cmp("start_state", 32'(state), S_PLAY);
        cmp("start_respawn", 32'(frog_respawn), 1);
        cmp("start_freeze", 32'(freeze), 0);
        cycle();
        cmp("respawn_single", 32'(frog_respawn), 0);

        // Death held for 100 cycles: one decrement, one respawn on return.
        resp_cnt = 0;
        death_collision = 1'b1;
        for (int i = 0; i < 100; i++) cycle();
        death_collision = 1'b0;
        cmp("hold_lives", 32'(lives), 2);
        cmp("hold_state", 32'(state), S_DYING);
        wait_state(S_PLAY, 800, "hold_resume");
        cmp("hold_respawn_cnt", 32'(resp_cnt), 1);

        // Death and win together: death wins.
        death_collision = 1'b1; win_collision = 1'b1;
        cycle();
        death_collision = 1'b0; win_collision = 1'b0;
        cmp("both_state", 32'(state), S_DYING);
        cmp("both_lives", 32'(lives), 1);
        cmp("both_level", 32'(level), 1);
        cmp("both_score", 32'(score), 0);
        wait_state(S_PLAY, 800, "both_resume");

        // Twelve wins: level saturates, score counts on.
        tick_period = 2;
        for (int i = 0; i < 12; i++) begin
            win_collision = 1'b1;
            cycle();
            win_collision = 1'b0;
            wait_state(S_PLAY, 200, "win_resume");
        end
        cmp("win_level_sat", 32'(level), MAX_LEVEL);
        cmp("win_score", 32'(score), 12);

        // Final death leads to OVER, then restart.
        death_collision = 1'b1;
        cycle();
        death_collision = 1'b0;
        wait_state(S_OVER, 300, "over_reach");
        cmp("over_game_over", 32'(game_over), 1);
        cmp("over_lives", 32'(lives), 0);
        cmp("over_freeze", 32'(freeze), 1);
        pulse_start();
        cmp("restart_lives", 32'(lives), LIVES_INIT);
        cmp("restart_score", 32'(score), 0);
`ifdef GAME_CTRL_CONTINUE_EN
        cmp("restart_level", 32'(level), MAX_LEVEL);
`else
        cmp("restart_level", 32'(level), 1);
`endif

        // Random stimulus against the model.
        tick_period = 0;
        for (int i = 0; i < 4000; i++) begin
            death_collision = ($urandom_range(0, 39) == 0);
            win_collision   = ($urandom_range(0, 19) == 0);
            start           = ($urandom_range(0, 29) == 0);
            cycle();
        end
        death_collision = 1'b0; win_collision = 1'b0; start = 1'b0;

        // Async reset in the middle of DYING.
        do_reset();
        tick_period = 3;
        pulse_start();
        death_collision = 1'b1;
        cycle();
        death_collision = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        cmp("mid_dying_state", 32'(state), S_DYING);
        do_reset();
        for (int i = 0; i < 20; i++) cycle();
        cmp("post_rst_idle", 32'(state), S_IDLE);
        pulse_start();
        cmp("post_rst_play", 32'(state), S_PLAY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frog_game_ctrl.md
# frog_game_ctrl

Game-state controller for the frogger datapath. It consumes the per-frame collision flags (`death_collision`, `win_collision`) and turns them into lives, level and score bookkeeping. It also produces the respawn and freeze controls that feed frog movement and car motion. It sits between the collision detector and the frog/car position logic and drives the score/level display.

## Interface
Parameters:
- LIVES_INIT, 3: lives at game start; legal range 1..3.
- DEATH_FRAMES, 60: frame_tick count spent in DYING.
- WIN_FRAMES, 30: frame_tick count spent in WIN.
- MAX_LEVEL, 9: level saturation value; legal range 1..15.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; asynchronous assert, active-low.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  one-cycle debounced button pulse.
- death_collision  in  1  frog/car overlap; level signal, may stay high many cycles.
- win_collision  in  1  frog at top row; level signal.
- frog_respawn  out  1  one-cycle pulse: reload frog start position.
- freeze  out  1  high = frog input and car motion inhibited.
- lives  out  2  remaining lives.
- level  out  4  current level, 1..MAX_LEVEL.
- score  out  7  completed crossings, saturating at 99.
- game_over  out  1  high while in OVER.
- state  out  3  encoded FSM state, for debug/display.

## Operation
- FSM states, with encoding:
  - IDLE=0
  - PLAY=1
  - DYING=2
  - WIN=3
  - OVER=4
- All outputs are registered. Reset values:
  - state=IDLE, freeze=1, frog_respawn=0, game_over=0
  - lives=LIVES_INIT, level=1, score=0
  - frame timer=0
- IDLE:
  - start → PLAY; pulse frog_respawn; freeze=0.
- PLAY:
  - death_collision=1 → DYING; lives decremented.
  - Otherwise win_collision=1 → WIN; level increments saturating at MAX_LEVEL; score increments saturating at 99.
  - Death has priority when both flags are high in the same cycle.
  - start is ignored.
- DYING / WIN:
  - freeze=1.
  - Collision inputs and start are ignored.
  - The frame timer counts frame_tick pulses.
  - On reaching DEATH_FRAMES (or WIN_FRAMES): WIN → PLAY, and DYING → PLAY if lives≠0, both with a frog_respawn pulse and freeze=0 in the transition cycle; DYING → OVER if lives=0.
- OVER:
  - freeze=1, game_over=1.
  - start → PLAY with a frog_respawn pulse; lives=LIVES_INIT, score=0; level per Configuration.
- The frame timer is 6 bits wide, sized for max(DEATH_FRAMES, WIN_FRAMES) ≤ 63. It clears on every state entry.
- lives never underflows: DYING is only entered from PLAY, and PLAY implies lives≥1.
- Collision flags that persist after a state change cause no repeated events, because they are only sampled in PLAY.
- frog_respawn resets the frog away from the collision region before PLAY samples again. Freshly respawned frog positions are valid by the next cycle.

## Timing
- Collision sampled high at edge N (state=PLAY):
  - state, lives/level/score and freeze update at edge N.
  - These values are visible from cycle N+1.
  - No collision sampled in PLAY during cycle N+1 can retrigger.
- A frame_tick coincident with the state-entry edge is not counted; counting starts on the following cycle.
- Exit from DYING/WIN occurs on the edge that samples the DEATH_FRAMES-th (WIN_FRAMES-th) counted tick.
- frog_respawn is high for exactly one cycle: the cycle after the transition edge into PLAY.
- start coincident with a collision in PLAY: collision handled, start dropped.
- Async reset mid-DYING/WIN/OVER: immediate return to the reset values above; no respawn pulse until the next start.

## Configuration
- GAME_CTRL_CONTINUE_EN defined: restart from OVER keeps the current level (continue mode); lives and score still reload.
- Undefined: restart from OVER sets level=1.

## Test plan
- Reset, then start: frog_respawn single pulse, freeze 1→0, state=1, lives=3, level=1.
- Hold death_collision high 100 cycles in PLAY with frame_tick every 10 cycles: exactly one decrement, lives=2. PLAY resumes after 60 counted ticks with one respawn pulse.
- death and win both high in the same cycle: state=DYING, lives decremented, level and score unchanged.
- 12 wins with MAX_LEVEL=9: level saturates at 9, score=12. Each WIN lasts 30 ticks.
- Three deaths: state=OVER, game_over=1, lives=0.
  - start gives lives=3, score=0.
  - level=1 without GAME_CTRL_CONTINUE_EN; level retained with it.
- rst_n asserted mid-DYING between clock edges: outputs reach their reset values without waiting for a clock edge. start is required to resume.
